// File: rtl/card_pkg.sv
// ============================================================================
// Module      : card_pkg
// Description : Shared card codes, slot indices, deal states and glyphs for
//               the baccarat card display path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_KING  = 4'd13;

    localparam logic [2:0] SLOT_P1 = 3'd0;
    localparam logic [2:0] SLOT_P2 = 3'd1;
    localparam logic [2:0] SLOT_P3 = 3'd2;
    localparam logic [2:0] SLOT_D1 = 3'd3;
    localparam logic [2:0] SLOT_D2 = 3'd4;
    localparam logic [2:0] SLOT_D3 = 3'd5;

    typedef enum logic [2:0] {
        S_P1    = 3'd0,
        S_D1    = 3'd1,
        S_P2    = 3'd2,
        S_D2    = 3'd3,
        S_THIRD = 3'd4,
        S_D3    = 3'd5,
        S_DONE  = 3'd6
    } deal_state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_J     = 7'b1100001;
    localparam logic [6:0] SEG_Q     = 7'b0011000;
    localparam logic [6:0] SEG_K     = 7'b0001001;

    // Baccarat point value: pips count face value, tens and faces count zero
    function automatic logic [4:0] card_value(input card_t card);
        return ((card >= CARD_ACE) && (card <= 4'd9)) ? {1'b0, card} : 5'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/card7seg.sv
// ============================================================================
// Module      : card7seg
// Description : Card code to active-low 7-segment glyph decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module card7seg
    import card_pkg::*;
#(
    parameter logic [6:0] BLANK_SEG = SEG_BLANK
) (
    input  card_t      card,
    output logic [6:0] seg
);

    always_comb begin
        seg = BLANK_SEG;
        case (card)
            4'd1:    seg = SEG_A;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            4'd10:   seg = 7'b1000000;
            4'd11:   seg = SEG_J;
            4'd12:   seg = SEG_Q;
            4'd13:   seg = SEG_K;
            default: seg = BLANK_SEG;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/card_slot_display.sv
// ============================================================================
// Module      : card_slot_display
// Description : Stores dealt baccarat cards in six display slots, checks the
//               deal order, scores both hands. Optional winner comparator is
//               enabled by defining BACCARAT_WINNER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module card_slot_display
    import card_pkg::*;
#(
    parameter logic [6:0] BLANK_SEG = SEG_BLANK,
    parameter int         SCORE_MOD = 10
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load_valid,
    input  logic [2:0] load_slot,
    input  logic [3:0] load_card,
    input  logic       hand_end,
    output logic       load_ready,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       deal_done,
    output logic       order_err,
    output logic [1:0] winner
);

    localparam logic [4:0] c_score_mod = 5'(SCORE_MOD);

    deal_state_t r_state;
    deal_state_t w_state_next;
    deal_state_t w_after_load;
    card_t       r_slot [6];
    logic        r_order_err;
    logic        w_card_ok;
    logic        w_slot_legal;
    logic        w_accept;
    logic        w_err;
    logic [4:0]  w_psum;
    logic [4:0]  w_dsum;
    logic [6:0]  w_seg [6];

    assign load_ready = (r_state != S_DONE);
    assign deal_done  = (r_state == S_DONE);
    assign order_err  = r_order_err;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_P1;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_card_ok    = (load_card >= CARD_ACE) && (load_card <= CARD_KING);
        w_slot_legal = 1'b0;
        w_after_load = r_state;
        case (r_state)
            S_P1: if (load_slot == SLOT_P1) begin
                w_slot_legal = 1'b1;
                w_after_load = S_D1;
            end
            S_D1: if (load_slot == SLOT_D1) begin
                w_slot_legal = 1'b1;
                w_after_load = S_P2;
            end
            S_P2: if (load_slot == SLOT_P2) begin
                w_slot_legal = 1'b1;
                w_after_load = S_D2;
            end
            S_D2: if (load_slot == SLOT_D2) begin
                w_slot_legal = 1'b1;
                w_after_load = S_THIRD;
            end
            S_THIRD: if (load_slot == SLOT_P3) begin
                w_slot_legal = 1'b1;
                w_after_load = S_D3;
            end else if (load_slot == SLOT_D3) begin
                w_slot_legal = 1'b1;
                w_after_load = S_DONE;
            end
            S_D3: if (load_slot == SLOT_D3) begin
                w_slot_legal = 1'b1;
                w_after_load = S_DONE;
            end
            default: w_slot_legal = 1'b0;
        endcase

        w_accept     = load_valid && load_ready && w_slot_legal && w_card_ok;
        w_err        = load_valid && !w_accept;
        w_state_next = w_accept ? w_after_load : r_state;

        // The load resolves first; hand_end then acts on the resulting state
        // unless that load itself finished the hand.
        if (hand_end && !(w_accept && (w_after_load == S_DONE))) begin
            if ((w_state_next == S_THIRD) || (w_state_next == S_D3)) begin
                w_state_next = S_DONE;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_order_err <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_slot[i] <= CARD_EMPTY;
            end
        end else begin
            if (w_err) begin
                r_order_err <= 1'b1;
            end
            if (w_accept) begin
                r_slot[load_slot] <= load_card;
            end
        end
    end

    assign w_psum = card_value(r_slot[SLOT_P1]) + card_value(r_slot[SLOT_P2])
                  + card_value(r_slot[SLOT_P3]);
    assign w_dsum = card_value(r_slot[SLOT_D1]) + card_value(r_slot[SLOT_D2])
                  + card_value(r_slot[SLOT_D3]);
    assign pscore = 4'(w_psum % c_score_mod);
    assign dscore = 4'(w_dsum % c_score_mod);

`ifdef BACCARAT_WINNER_EN
    always_comb begin
        winner = 2'b00;
        if (r_state == S_DONE) begin
            if (pscore > dscore) begin
                winner = 2'b01;
            end else if (dscore > pscore) begin
                winner = 2'b10;
            end else begin
                winner = 2'b11;
            end
        end
    end
`else
    assign winner = 2'b00;
`endif

    for (genvar gi = 0; gi < 6; gi++) begin : g_seg
        card7seg #(
            .BLANK_SEG (BLANK_SEG)
        ) u_card7seg (
            .card (r_slot[gi]),
            .seg  (w_seg[gi])
        );
    end

    assign hex0 = w_seg[0];
    assign hex1 = w_seg[1];
    assign hex2 = w_seg[2];
    assign hex3 = w_seg[3];
    assign hex4 = w_seg[4];
    assign hex5 = w_seg[5];

endmodule

`default_nettype wire

// File: tb/tb_card_slot_display.sv
// ============================================================================
// Module      : tb_card_slot_display
// Description : Self-checking bench for card_slot_display (vector table,
//               hand-written reset sequence, randomized hands vs. a model).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_card_slot_display;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic       load_valid = 1'b0;
    logic [2:0] load_slot  = 3'd0;
    logic [3:0] load_card  = 4'd0;
    logic       hand_end   = 1'b0;
    logic       load_ready;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [3:0] pscore, dscore;
    logic       deal_done, order_err;
    logic [1:0] winner;
    logic [6:0] hex_arr [6];

    int checks = 0;
    int errors = 0;

    card_slot_display dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .load_valid (load_valid),
        .load_slot  (load_slot),
        .load_card  (load_card),
        .hand_end   (hand_end),
        .load_ready (load_ready),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .pscore     (pscore),
        .dscore     (dscore),
        .deal_done  (deal_done),
        .order_err  (order_err),
        .winner     (winner)
    );

    always #5 slow_clock = ~slow_clock;

    always_comb begin
        hex_arr[0] = hex0;
        hex_arr[1] = hex1;
        hex_arr[2] = hex2;
        hex_arr[3] = hex3;
        hex_arr[4] = hex4;
        hex_arr[5] = hex5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_card [6];
    int m_count;
    bit m_done;
    bit m_err;

    function automatic logic [6:0] glyph(input int code);
        case (code)
            1:  return 7'b0001000;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b1000000;
            11: return 7'b1100001;
            12: return 7'b0011000;
            13: return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int points(input int code);
        return (code >= 1 && code <= 9) ? code : 0;
    endfunction

    function automatic int hand_score(input int base);
        return (points(m_card[base]) + points(m_card[base+1]) + points(m_card[base+2])) % 10;
    endfunction

    // Deal order: P1, D1, P2, D2, then optional P3, then optional D3 (last).
    function automatic bit slot_legal(input int s);
        if (m_done) return 1'b0;
        case (m_count)
            0: return s == 0;
            1: return s == 3;
            2: return s == 1;
            3: return s == 4;
            4: return (s == 2) || (s == 5);
            default: return s == 5;
        endcase
    endfunction

    function automatic int legal_slot();
        if (m_done) return int'($urandom_range(0, 5));
        case (m_count)
            0: return 0;
            1: return 3;
            2: return 1;
            3: return 4;
            4: return ($urandom_range(0, 1) == 0) ? 2 : 5;
            default: return 5;
        endcase
    endfunction

    function automatic logic [1:0] exp_winner();
`ifdef BACCARAT_WINNER_EN
        if (!m_done) return 2'b00;
        if (hand_score(0) > hand_score(3)) return 2'b01;
        if (hand_score(3) > hand_score(0)) return 2'b10;
        return 2'b11;
`else
        return 2'b00;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_card[i] = 0;
        m_count = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit v, input int s, input int c, input bit h);
        bit acc;
        acc = 1'b0;
        if (v) begin
            if (slot_legal(s) && c >= 1 && c <= 13) begin
                m_card[s] = c;
                m_count++;
                acc = 1'b1;
                if (s == 5) m_done = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        if (h && !(acc && m_done)) begin
            if (!m_done && m_count >= 4) m_done = 1'b1;
            else m_err = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s hex%0d", tag, i), hex_arr[i], glyph(m_card[i]));
        check({tag, " pscore"}, pscore, hand_score(0));
        check({tag, " dscore"}, dscore, hand_score(3));
        check({tag, " deal_done"}, deal_done, m_done);
        check({tag, " order_err"}, order_err, m_err);
        check({tag, " load_ready"}, load_ready, !m_done);
        check({tag, " winner"}, winner, exp_winner());
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic apply(input bit v, input int s, input int c, input bit h);
        load_valid = v;
        load_slot  = 3'(s);
        load_card  = 4'(c);
        hand_end   = h;
        @(posedge slow_clock);
        #1;
        model_step(v, s, c, h);
        load_valid = 1'b0;
        hand_end   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge slow_clock);
        resetb = 1'b0;
        model_reset();
        repeat (2) @(posedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s hex%0d", tag, i), hex_arr[i], 7'b1111111);
        check({tag, " pscore"}, pscore, 0);
        check({tag, " dscore"}, dscore, 0);
        check({tag, " load_ready"}, load_ready, 1);
        check({tag, " order_err"}, order_err, 0);
        check({tag, " deal_done"}, deal_done, 0);
        check({tag, " winner"}, winner, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rst;
        bit         v;
        int         s;
        int         c;
        bit         h;
        int         ep;
        int         ed;
        bit         edone;
        bit         eerr;
        int         hidx;
        logic [6:0] ehex;
        logic [1:0] ewin;
    } vec_t;

    vec_t vt [$];

    task automatic add(input bit rst, input bit v, input int s, input int c, input bit h,
                       input int ep, input int ed, input bit edone, input bit eerr,
                       input int hidx, input logic [6:0] ehex, input logic [1:0] ewin);
        vec_t r;
        r.rst = rst; r.v = v; r.s = s; r.c = c; r.h = h;
        r.ep = ep; r.ed = ed; r.edone = edone; r.eerr = eerr;
        r.hidx = hidx; r.ehex = ehex; r.ewin = ewin;
        vt.push_back(r);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        // natural hand
        add(1,1,0,9,0,  9,0,0,0, 0,7'b0010000,2'b00);
        add(0,1,3,3,0,  9,3,0,0, 3,7'b0110000,2'b00);
        add(0,1,1,13,0, 9,3,0,0, 1,7'b0001001,2'b00);
        add(0,1,4,4,0,  9,7,0,0, 4,7'b0011001,2'b00);
        add(0,0,0,0,1,  9,7,1,0, 0,7'b0010000,2'b01);
        // full six-card hand, then a load after completion
        add(1,1,0,5,0,  5,0,0,0, 0,7'b0010010,2'b00);
        add(0,1,3,6,0,  5,6,0,0, 3,7'b0000010,2'b00);
        add(0,1,1,7,0,  2,6,0,0, 1,7'b1111000,2'b00);
        add(0,1,4,8,0,  2,4,0,0, 4,7'b0000000,2'b00);
        add(0,1,2,1,0,  3,4,0,0, 2,7'b0001000,2'b00);
        add(0,1,5,2,0,  3,6,1,0, 5,7'b0100100,2'b10);
        add(0,1,1,9,0,  3,6,1,1, 1,7'b1111000,2'b10);
        // order violation
        add(1,1,3,4,0,  0,0,0,1, 3,7'b1111111,2'b00);
        add(0,1,0,4,0,  4,0,0,1, 0,7'b0011001,2'b00);
        // invalid card code, state stays at first slot
        add(1,1,0,14,0, 0,0,0,1, 0,7'b1111111,2'b00);
        add(0,1,0,2,0,  2,0,0,1, 0,7'b0100100,2'b00);
        // premature hand_end
        add(1,0,0,0,1,  0,0,0,1, 0,7'b1111111,2'b00);
        // load into third-card state with simultaneous hand_end
        add(1,1,0,1,0,  1,0,0,0, 0,7'b0001000,2'b00);
        add(0,1,3,2,0,  1,2,0,0, 3,7'b0100100,2'b00);
        add(0,1,1,3,0,  4,2,0,0, 1,7'b0110000,2'b00);
        add(0,1,4,5,1,  4,7,1,0, 4,7'b0010010,2'b10);
        // last dealer card with simultaneous hand_end is absorbed
        add(1,1,0,6,0,  6,0,0,0, 0,7'b0000010,2'b00);
        add(0,1,3,10,0, 6,0,0,0, 3,7'b1000000,2'b00);
        add(0,1,1,2,0,  8,0,0,0, 1,7'b0100100,2'b00);
        add(0,1,4,1,0,  8,1,0,0, 4,7'b0001000,2'b00);
        add(0,1,5,3,1,  8,4,1,0, 5,7'b0110000,2'b01);

        model_reset();
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) begin
                do_reset();
                #1;
                check_reset_values($sformatf("vec%0d reset", i));
            end
            apply(vt[i].v, vt[i].s, vt[i].c, vt[i].h);
            check($sformatf("vec%0d pscore", i), pscore, vt[i].ep);
            check($sformatf("vec%0d dscore", i), dscore, vt[i].ed);
            check($sformatf("vec%0d deal_done", i), deal_done, vt[i].edone);
            check($sformatf("vec%0d order_err", i), order_err, vt[i].eerr);
            check($sformatf("vec%0d load_ready", i), load_ready, !vt[i].edone);
            check($sformatf("vec%0d hex%0d", i, vt[i].hidx), hex_arr[vt[i].hidx], vt[i].ehex);
`ifdef BACCARAT_WINNER_EN
            check($sformatf("vec%0d winner", i), winner, vt[i].ewin);
`else
            check($sformatf("vec%0d winner", i), winner, 2'b00);
`endif
            check_model($sformatf("vec%0d model", i));
        end

        // asynchronous reset between clock edges
        do_reset();
        apply(1, 0, 2, 0);
        apply(1, 3, 3, 0);
        apply(1, 1, 4, 0);
        check_model("async pre");
        @(negedge slow_clock);
        #2;
        resetb = 1'b0;
        model_reset();
        #1;
        check_reset_values("async reset");
        @(negedge slow_clock);
        resetb = 1'b1;
        apply(1, 0, 8, 0);
        check("async redeal pscore", pscore, 8);
        check("async redeal hex0", hex0, 7'b0000000);
        check_model("async redeal");

        // randomized hands against the model
        for (int hnd = 0; hnd < 30; hnd++) begin
            do_reset();
            for (int op = 0; op < 12; op++) begin
                int sel, s, c;
                bit v, h;
                sel = int'($urandom_range(0, 9));
                v = 1'b1;
                h = 1'b0;
                s = legal_slot();
                c = int'($urandom_range(1, 13));
                if (sel == 7) begin
                    s = int'($urandom_range(0, 7));
                    c = int'($urandom_range(0, 15));
                end else if (sel == 8) begin
                    v = 1'b0;
                    h = 1'b1;
                end else if (sel == 9) begin
                    h = 1'b1;
                end
                apply(v, s, c, h);
                check_model($sformatf("rand h%0d op%0d", hnd, op));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
